// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the pipeline: datapath width, writeback
// select encodings and load funct3 encodings, plus a load alignment helper.
// Ports: none (package).
package riscv_pkg;

  localparam int XLEN = 32;

  // Writeback source select (mem_wb_sel). 2'b11 is reserved and treated as ALU.
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  // Load funct3 encodings. 3'b011, 3'b110 and 3'b111 are not loads in RV32I.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A halfword must sit on an even address, a word on a multiple of four.
  // Byte loads and undefined encodings can never be misaligned.
  function automatic logic load_is_misaligned(input logic [2:0] funct3,
                                              input logic [1:0] addr);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: mis = addr[0];
      F3_LW:         mis = (addr != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load alignment: picks the addressed byte/halfword out of the raw memory
// word and sign- or zero-extends it; also reports a misaligned access.
// Ports: funct3/addr/raw in, data/misalign out. Purely combinational.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
  end

  // Halfword lane follows addr[1] only; addr[0] just flags misalignment,
  // so a misaligned LH still yields a deterministic (discarded) value.
  assign half_sel = addr[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data = raw;
      default: data = '0;  // undefined load type writes zero
    endcase
  end

  assign misalign = load_is_misaligned(funct3, addr);

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback select: registers MEM results,
// aligns load data, drives the register file write port, counts retirements.
// Ports: clk/reset/stall/flush control, mem_* MEM-stage inputs,
//        wb_* regfile write port, load_misalign pulse, retire_count.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN_P = 32,   // only 32 is supported (matches riscv_pkg::XLEN)
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_rd,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_funct3,
  input  logic [XLEN_P-1:0] mem_alu_result,
  input  logic [XLEN_P-1:0] mem_pc_plus4,
  input  logic [XLEN_P-1:0] mem_load_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [XLEN_P-1:0] wb_write_data,
  output logic              load_misalign,
  output logic [CNT_W-1:0]  retire_count
);

  logic [XLEN_P-1:0] load_data;
  logic              ext_misalign;
  logic              misalign;
  logic              writes_rd;
  logic              retires;
  logic [XLEN_P-1:0] wb_data_next;

  load_extend u_load_extend (
    .funct3   (mem_funct3),
    .addr     (mem_alu_result[1:0]),
    .raw      (mem_load_data),
    .data     (load_data),
    .misalign (ext_misalign)
  );

  // Only a real load instruction can be misaligned; the address bits of an
  // ALU result or a bubble are meaningless here.
  assign misalign  = mem_valid && (mem_wb_sel == WB_SEL_LOAD) && ext_misalign;
  assign writes_rd = mem_valid && mem_reg_write && (mem_rd != 5'd0) && !misalign;
  // Writes to x0 still retire; only a faulting load does not.
  assign retires   = mem_valid && !misalign;

  always_comb begin
    wb_data_next = mem_alu_result;
    case (mem_wb_sel)
      WB_SEL_LOAD: wb_data_next = load_data;
      WB_SEL_PC4:  wb_data_next = mem_pc_plus4;
      default:     wb_data_next = mem_alu_result;  // ALU and reserved
    endcase
  end

  // Priority: reset > flush > stall > capture. A flush kills the slot but
  // keeps the retirement count; a stall freezes everything including the
  // misalign pulse, so a stalled fault is not reported twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= 5'd0;
      wb_write_data <= '0;
      load_misalign <= 1'b0;
      retire_count  <= '0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= 5'd0;
      wb_write_data <= '0;
      load_misalign <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      wb_reg_write  <= writes_rd;
      wb_rd         <= mem_rd;
      wb_write_data <= wb_data_next;
      load_misalign <= misalign;
      if (retires) begin
        retire_count <= retire_count + 1'b1;  // wraps naturally
      end
    end
  end

endmodule
